// File: rtl/io_out_port.sv
// General-output IO port: captures CPU bus bytes on c_go into a small FIFO and
// hands them to an external consumer over valid/ready, with sticky overflow status.
module io_out_port #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_go,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             io_full,
    output logic             io_empty,
    output logic [CW-1:0]    io_count,
    output logic             io_overflow,
    input  logic             ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = w_valid & out_ready;
    // A write at full is still accepted when the head leaves in the same cycle.
    assign w_push  = c_go & (~w_full | w_pop);
    assign w_drop  = c_go & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= bus_in;
    end

    assign out_valid   = w_valid;
    assign out_data    = w_valid ? r_mem[r_rd_ptr] : '0;
    assign io_full     = w_full;
    assign io_empty    = ~w_valid;
    assign io_count    = r_count;
    assign io_overflow = r_overflow;

endmodule

// File: doc/io_out_port.md
Name: io_out_port

Overview:
Peripheral end of the CPU's general-output IO interface. In a cycle where the controller asserts c_go, the CPU drives a byte onto the data bus. This block captures that byte into a small FIFO. It then presents the bytes to an external consumer over a valid/ready handshake, in order. It also reports full/overflow status back to the core so firmware or the sequencer can avoid losing output.

Parameters:
WIDTH, 8, data bus width in bits
DEPTH, 4, FIFO entries; power of two, minimum 2
CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
c_go  input  1  write strobe from the controller (MOUT_STORE / ROUT_STORE states)
bus_in  input  WIDTH  CPU data bus; sampled only when c_go=1
out_data  output  WIDTH  byte at FIFO head; meaningful only when out_valid=1
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
io_full  output  1  count==DEPTH
io_empty  output  1  count==0
io_count  output  CW  current occupancy, 0..DEPTH
io_overflow  output  1  sticky: a c_go write was dropped since the last reset/clear
ovf_clr  input  1  clears io_overflow

Behaviour:
- Reset: one clk edge with rst=1 forces the following, regardless of other inputs:
  - read and write pointers = 0, count = 0
  - io_overflow = 0, out_valid = 0, io_empty = 1, io_full = 0
  - out_data = 0
- Storage: circular buffer of DEPTH×WIDTH, with wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH with no gap.
- pop = out_valid & out_ready. A pop advances rd_ptr by one and decrements count. Data is removed at that edge.
- push_req = c_go.
- A push is accepted when count<DEPTH, or when count==DEPTH and pop=1 in the same cycle (pass-through at full).
- An accepted push writes bus_in to mem[wr_ptr], advances wr_ptr and increments count.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance.
- Push into an empty FIFO: out_valid rises on the next cycle. There is no same-cycle bypass, so minimum latency from c_go to out_valid is 1 cycle.
- out_data is combinationally mem[rd_ptr]. When out_valid=1 it is stable until the pop edge.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid stay constant.
  - out_ready while empty has no effect.
- Overflow: c_go with count==DEPTH and pop=0 drops the byte. FIFO contents, pointers and count are untouched, and io_overflow is set at that edge.
- io_overflow is cleared by ovf_clr=1 or rst. If ovf_clr and a new drop occur in the same cycle, set wins and io_overflow=1.
- io_full, io_empty and io_count are decoded from the registered count, so they reflect the state after the last edge.
- c_go pulses in back-to-back cycles are all legal. Each one is an independent push.
- Reset asserted mid-transfer: all contents are discarded. No partial handshake survives, and out_valid=0 on the cycle after reset.
- X on bus_in when c_go=0 must not propagate into storage.

Test Plan:
- Reset, then a single c_go with bus_in=0x5A while out_ready=0. Next cycle: out_valid=1, out_data=0x5A, io_count=1. Raise out_ready: one cycle later io_empty=1, out_valid=0.
- Four c_go writes 0x11,0x22,0x33,0x44 with out_ready=0. Then io_full=1 and io_count=4. A fifth c_go with 0x55 sets io_overflow=1 and io_count stays 4. Draining with out_ready=1 yields 0x11,0x22,0x33,0x44 in order, and 0x55 never appears.
- Full FIFO (0x11..0x44), then c_go=0x55 together with out_ready=1 in the same cycle. 0x11 pops, 0x55 is accepted, io_count stays 4 and io_overflow stays 0. Drain order is 0x22,0x33,0x44,0x55.
- Continuous streaming: c_go every cycle for 10 cycles with bytes 0x00..0x09 and out_ready=1 throughout. io_count stays ≤1, pointers wrap past DEPTH, output is 0x00..0x09 in order, and there is no overflow.
- ovf_clr asserted in the same cycle as a new dropped write at full: io_overflow stays 1. Then ovf_clr alone: io_overflow=0 on the next cycle.
- Write 0xAA and 0xBB, then assert rst for one cycle while out_ready toggles. After reset: io_empty=1, io_count=0, out_valid=0, io_overflow=0. A subsequent c_go of 0xCC appears as the first output.
